// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, FSM states, ALU codes
// and the control-strobe bundle shared by the multicycle core.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7
  } alu_op_t;

  typedef enum logic [1:0] {
    SB_B,
    SB_FOUR,
    SB_IMM,
    SB_BOFS
  } src_b_t;

  typedef enum logic [1:0] {
    PS_ALU,
    PS_OUT,
    PS_JMP
  } pc_src_t;

  typedef struct packed {
    logic    pc_write;
    pc_src_t pc_src;
    logic    ir_write;
    logic    ab_write;
    logic    out_write;
    logic    mdr_write;
    logic    reg_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    src_a;
    src_b_t  src_b;
    alu_op_t alu_op;
    logic    mem_req;
    logic    mem_we;
    logic    addr_out;
    logic    halted;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_op_t funct_op(input logic [5:0] f);
    alu_op_t op;
    case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// mips_mc_control: state register, next-state logic and per-state
// strobes. In: clk, rst, opcode, funct, mem_ready, zero. Out: ctrl.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.src_b   = SB_FOUR;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PS_ALU;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.ab_write  = 1'b1;
        ctrl.out_write = 1'b1;
        ctrl.src_b     = SB_BOFS;
        unique case (1'b1)
          (opcode == OP_R) && funct_ok(funct):
            state_d = S_EXEC_R;
          opcode == OP_ADDI:
            state_d = S_EXEC_I;
          (opcode == OP_LW) || (opcode == OP_SW):
            state_d = S_MEM_ADDR;
          opcode == OP_BEQ:
            state_d = S_BRANCH;
          opcode == OP_J:
            state_d = S_JUMP;
          default:
            state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ctrl.src_a     = 1'b1;
        ctrl.src_b     = SB_B;
        ctrl.alu_op    = funct_op(funct);
        ctrl.out_write = 1'b1;
        state_d        = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.src_a     = 1'b1;
        ctrl.src_b     = SB_IMM;
        ctrl.out_write = 1'b1;
        state_d        = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ctrl.src_a     = 1'b1;
        ctrl.src_b     = SB_IMM;
        ctrl.out_write = 1'b1;
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_out = 1'b1;
        if (mem_ready) begin
          ctrl.mdr_write = 1'b1;
          state_d        = S_WB_MEM;
        end
      end
      S_MEM_WR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_out = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (opcode == OP_R);
        state_d        = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.pc_write = zero;
        ctrl.pc_src   = PS_OUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PS_JMP;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    // A pending access is withdrawn in the cycle reset is seen.
    if (rst) begin
      ctrl.mem_req = 1'b0;
      ctrl.mem_we  = 1'b0;
      ctrl.halted  = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS datapath (PC, IR, A, B, ALUOut,
// MDR, regfile, ALU). Ports: clk, rst, mem_* handshake, pc_out, halted.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              halted
);

  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] out_q;
  logic [31:0] mdr_q;
  logic [31:0] rf_q [32];

  ctrl_t       ctrl;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wa;
  logic [31:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_y;
  logic [31:0] pc_next;
  logic [31:0] wb_data;

  assign rs  = ir_q[25:21];
  assign rt  = ir_q[20:16];
  assign rd  = ir_q[15:11];
  assign imm = {{16{ir_q[15]}}, ir_q[15:0]};

  assign rs_val  = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val  = (rt == 5'd0) ? '0 : rf_q[rt];
  assign wa      = ctrl.reg_dst ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? mdr_q : out_q;

  mips_mc_control u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .opcode    (ir_q[31:26]),
    .funct     (ir_q[5:0]),
    .mem_ready (mem_ready),
    .zero      (a_q == b_q),
    .ctrl      (ctrl)
  );

  assign src_a = ctrl.src_a ? a_q : pc_q;

  always_comb begin
    unique case (ctrl.src_b)
      SB_B:    src_b = b_q;
      SB_FOUR: src_b = 32'd4;
      SB_IMM:  src_b = imm;
      default: src_b = imm << 2;
    endcase
  end

  always_comb begin
    unique case (ctrl.alu_op)
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_SLT: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_y = src_a + src_b;
    endcase
  end

  always_comb begin
    unique case (ctrl.pc_src)
      PS_OUT:  pc_next = out_q;
      PS_JMP:  pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_next = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (ctrl.pc_write)  pc_q  <= pc_next;
      if (ctrl.ir_write)  ir_q  <= mem_rdata;
      if (ctrl.ab_write) begin
        a_q <= rs_val;
        b_q <= rt_val;
      end
      if (ctrl.out_write) out_q <= alu_y;
      if (ctrl.mdr_write) mdr_q <= mem_rdata;
      if (ctrl.reg_write && (wa != 5'd0)) rf_q[wa] <= wb_data;
    end
  end

  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign mem_addr  = ctrl.addr_out ? out_q[ADDR_W-1:0]
                                   : pc_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = ctrl.halted;

endmodule
